pulse_swallow_div: RTL and testbench
====================================

Name: pulse_swallow_div

Overview:
- Parametrised programmable integer clock divider built on the dual-modulus principle.
- An internal prescaler divides by M or M+1 under a modulus control. A program counter (P) and a swallow counter (S) give the total ratio N = P*M + S.
- Fully synchronous to clk_in: no derived or gated clocks inside the block. It replaces the fixed /3-/4 prescaler stage in the divider chain.

Parameters:
- M, 4: prescaler base modulus; prescaler divides by M (mod_ctrl=0) or M+1 (mod_ctrl=1); M >= 2.
- P_W, 6: width of p_val and the program counter.
- S_W, 2: width of s_val and the swallow counter; must satisfy 2^S_W <= M.
- P_RST, 5: active P after reset.
- S_RST, 0: active S after reset.

Ports:
- clk_in, input, 1: input clock; all state updates on its rising edge.
- rstb, input, 1: asynchronous active-low reset.
- p_val, input, P_W: requested program count P.
- s_val, input, S_W: requested swallow count S.
- load, input, 1: one-cycle strobe; captures p_val/s_val as a pending ratio.
- clk_out, output, 1: divided clock, registered.
- mod_ctrl, output, 1: current prescaler modulus select (1 = /(M+1)).
- cycle_done, output, 1: one-cycle pulse on the last clk_in cycle of each output period.
- ratio_err, output, 1: last load was rejected.

Behaviour:
- Reset (rstb=0, asynchronous):
  - pre_cnt=0, p_cnt=0.
  - Active P=P_RST, active S=S_RST; s_cnt=S_RST.
  - Pending flag cleared.
  - clk_out=1, cycle_done=0, ratio_err=0.
  - mod_ctrl = (s_cnt != 0).
  - load is ignored while rstb=0.
- Prescaler counter pre_cnt:
  - Counts 0..M-1 when mod_ctrl=0, or 0..M when mod_ctrl=1, then wraps to 0.
  - The wrap edge ends a prescaler period.
- At each prescaler-period end:
  - If p_cnt == P_act-1 (output-period boundary): p_cnt <= 0. If the pending flag is set, P_act/S_act <= pending values and the flag clears. s_cnt <= new S_act.
  - Otherwise: p_cnt <= p_cnt+1; s_cnt <= s_cnt-1 if s_cnt != 0.
- mod_ctrl = (s_cnt != 0), decoded from registers. The first S_act prescaler periods are M+1 long and the remaining P_act-S_act are M long, so the period is exactly P_act*M + S_act clk_in cycles.
- clk_out:
  - Registered. After each edge it equals 1 iff the post-edge p_cnt < (P_act+1)>>1.
  - The duty cycle is therefore ceil(P/2) prescaler periods high.
  - The rising edge of clk_out coincides with the first clk_in edge after the boundary.
- cycle_done = 1 during the clk_in cycle where pre_cnt is at its terminal value and p_cnt == P_act-1.
- Load validation:
  - Valid iff p_val >= 2 and p_val >= s_val.
  - Valid load: pending <= {p_val,s_val}, flag set, ratio_err <= 0.
  - Invalid load: pending untouched, ratio_err <= 1.
  - ratio_err holds until the next load.
- Load timing:
  - Multiple loads before a boundary: the last valid one wins.
  - A load on the same edge as a boundary does NOT affect that boundary; it applies at the following boundary.
- Ratio changes only at boundaries, so there is never a truncated or extended output period. The new P_act also governs clk_out duty from the first period it applies to.
- rstb asserted mid-period: immediate return to reset state; any pending ratio is discarded.

Test Plan:
- Reset defaults (M=4, P=5, S=0): release rstb -> clk_out period 20 clk_in cycles, 12 high / 8 low; mod_ctrl stays 0; cycle_done pulses every 20 cycles.
- Swallow (load P=5, S=2) -> from next boundary: period 22; prescaler periods 5,5,4,4,4; clk_out 14 high / 8 low; mod_ctrl high for the first 10 cycles of each period.
- Mid-period reload (P=3, S=0 loaded 7 cycles into a 22 period) -> current period still 22, next period 12 (8 high / 4 low); a load on the boundary edge is delayed one period.
- Invalid loads (P=2 S=3, then P=1 S=0) -> ratio_err=1 after each; active ratio unchanged; a subsequent valid load P=4 S=1 clears ratio_err and gives period 17.
- Max ratio (P=63, S=3) -> period 255, clk_out high 32 prescaler periods = 131 cycles; p_cnt and s_cnt wrap cleanly with no overflow.
- Reset mid-operation (rstb low 3 cycles during period) -> outputs immediately at reset values; pending ratio discarded; resumes at P_RST/S_RST.

Source files
------------

// File: rtl/pulse_swallow_div.sv
// Dual-modulus (M / M+1) programmable clock divider, total ratio N = P*M + S.
// Latency: clk_out registered, changes one clk_in edge after the internal counters decide.
// Backpressure: none; a load is held as pending and applied at the next output-period boundary.
module pulse_swallow_div #(
    parameter int M     = 4,
    parameter int P_W   = 6,
    parameter int S_W   = 2,
    parameter int P_RST = 5,
    parameter int S_RST = 0
) (
    input  logic           clk_in,
    input  logic           rstb,
    input  logic [P_W-1:0] p_val,
    input  logic [S_W-1:0] s_val,
    input  logic           load,
    output logic           clk_out,
    output logic           mod_ctrl,
    output logic           cycle_done,
    output logic           ratio_err
);

    localparam int PRE_W = $clog2(M + 1);
    localparam int CMP_W = P_W + S_W;

    logic [PRE_W-1:0] r_pre_cnt;
    logic [P_W-1:0]   r_p_cnt;
    logic [S_W-1:0]   r_s_cnt;
    logic [P_W-1:0]   r_p_act;
    logic [S_W-1:0]   r_s_act;
    logic [P_W-1:0]   r_p_pend;
    logic [S_W-1:0]   r_s_pend;
    logic             r_pend_vld;
    logic             r_clk_out;
    logic             r_ratio_err;

    logic             w_pre_term;
    logic             w_bound;
    logic             w_load_ok;
    logic [P_W-1:0]   w_p_act_nxt;
    logic [S_W-1:0]   w_s_act_nxt;
    logic [P_W-1:0]   w_p_cnt_nxt;
    logic [S_W-1:0]   w_s_cnt_nxt;
    logic [P_W:0]     w_half;

    // Swallow periods come first: the prescaler runs /(M+1) while s_cnt is non-zero.
    assign mod_ctrl   = (r_s_cnt != '0);
    assign w_pre_term = mod_ctrl ? (r_pre_cnt == PRE_W'(M)) : (r_pre_cnt == PRE_W'(M - 1));
    assign w_bound    = w_pre_term && (r_p_cnt == r_p_act - P_W'(1));
    assign cycle_done = w_bound;
    assign clk_out    = r_clk_out;
    assign ratio_err  = r_ratio_err;

    assign w_load_ok = (p_val >= P_W'(2)) && (CMP_W'(p_val) >= CMP_W'(s_val));

    always_comb begin
        w_p_act_nxt = r_p_act;
        w_s_act_nxt = r_s_act;
        w_p_cnt_nxt = r_p_cnt;
        w_s_cnt_nxt = r_s_cnt;
        if (w_bound) begin
            w_p_cnt_nxt = '0;
            if (r_pend_vld) begin
                w_p_act_nxt = r_p_pend;
                w_s_act_nxt = r_s_pend;
            end
            w_s_cnt_nxt = w_s_act_nxt;
        end else if (w_pre_term) begin
            w_p_cnt_nxt = r_p_cnt + P_W'(1);
            if (r_s_cnt != '0) begin
                w_s_cnt_nxt = r_s_cnt - S_W'(1);
            end
        end
        // High for ceil(P/2) prescaler periods of the ratio in force after this edge.
        w_half = ({1'b0, w_p_act_nxt} + (P_W + 1)'(1)) >> 1;
    end

    always_ff @(posedge clk_in or negedge rstb) begin
        if (!rstb) begin
            r_pre_cnt   <= '0;
            r_p_cnt     <= '0;
            r_s_cnt     <= S_W'(S_RST);
            r_p_act     <= P_W'(P_RST);
            r_s_act     <= S_W'(S_RST);
            r_p_pend    <= '0;
            r_s_pend    <= '0;
            r_pend_vld  <= 1'b0;
            r_clk_out   <= 1'b1;
            r_ratio_err <= 1'b0;
        end else begin
            r_pre_cnt <= w_pre_term ? '0 : r_pre_cnt + PRE_W'(1);
            r_p_cnt   <= w_p_cnt_nxt;
            r_s_cnt   <= w_s_cnt_nxt;
            r_p_act   <= w_p_act_nxt;
            r_s_act   <= w_s_act_nxt;
            r_clk_out <= ({1'b0, w_p_cnt_nxt} < w_half);
            if (w_bound) begin
                r_pend_vld <= 1'b0;
            end
            // A load on a boundary edge lands in pending, so it waits for the following boundary.
            if (load) begin
                if (w_load_ok) begin
                    r_p_pend    <= p_val;
                    r_s_pend    <= s_val;
                    r_pend_vld  <= 1'b1;
                    r_ratio_err <= 1'b0;
                end else begin
                    r_ratio_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_swallow_div.sv
// Directed bench for pulse_swallow_div (M=4, P_W=6, S_W=2, reset ratio 5/0).
module tb_pulse_swallow_div;

    logic       clk_in;
    logic       rstb;
    logic [5:0] p_val;
    logic [1:0] s_val;
    logic       load;
    logic       clk_out;
    logic       mod_ctrl;
    logic       cycle_done;
    logic       ratio_err;

    int n_chk  = 0;
    int n_pass = 0;

    pulse_swallow_div #(
        .M(4), .P_W(6), .S_W(2), .P_RST(5), .S_RST(0)
    ) dut (
        .clk_in     (clk_in),
        .rstb       (rstb),
        .p_val      (p_val),
        .s_val      (s_val),
        .load       (load),
        .clk_out    (clk_out),
        .mod_ctrl   (mod_ctrl),
        .cycle_done (cycle_done),
        .ratio_err  (ratio_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Count negedges up to and including the next cycle_done cycle.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (cnt < 400) begin
            @(negedge clk_in);
            cnt++;
            if (cycle_done) break;
        end
    endtask

    // Called at the negedge of a cycle_done cycle: measures the following full output period.
    task automatic measure(output int per, output int hi, output int md);
        per = 0; hi = 0; md = 0;
        while (per < 400) begin
            @(negedge clk_in);
            per++;
            hi += int'(clk_out);
            md += int'(mod_ctrl);
            if (cycle_done) break;
        end
    endtask

    task automatic do_load(input int p, input int s);
        p_val = 6'(p);
        s_val = 2'(s);
        load  = 1'b1;
        @(negedge clk_in);
        load  = 1'b0;
    endtask

    int per, hi, md, cnt;

    initial begin
        rstb = 1'b1; load = 1'b0; p_val = '0; s_val = '0;
        #2 rstb = 1'b0;
        step(3);
        check("rst_clk_out", int'(clk_out), 1);
        check("rst_cycle_done", int'(cycle_done), 0);
        check("rst_ratio_err", int'(ratio_err), 0);
        check("rst_mod_ctrl", int'(mod_ctrl), 0);
        rstb = 1'b1;

        // Defaults 5/0: 20 cycles, 12 high
        wait_done(cnt);
        check("dflt_first_per", cnt, 19);
        measure(per, hi, md);
        check("dflt_per", per, 20);
        check("dflt_hi", hi, 12);
        check("dflt_mod", md, 0);

        // Swallow 5/2: 22 cycles, 14 high, 10 at /5
        step(2);
        do_load(5, 2);
        check("swl_err", int'(ratio_err), 0);
        wait_done(cnt);
        measure(per, hi, md);
        check("swl_per", per, 22);
        check("swl_hi", hi, 14);
        check("swl_mod", md, 10);

        // Mid-period reload 3/0: current period stays 22, next is 12 (8 high)
        step(7);
        do_load(3, 0);
        wait_done(cnt);
        check("mid_cur_per", 7 + 1 + cnt, 22);
        measure(per, hi, md);
        check("mid_new_per", per, 12);
        check("mid_new_hi", hi, 8);
        check("mid_new_mod", md, 0);

        // Load on the boundary edge: the period it starts is still 12, the one after is 20
        p_val = 6'd5; s_val = 2'd0; load = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
        wait_done(cnt);
        check("bnd_load_per", 1 + cnt, 12);
        measure(per, hi, md);
        check("bnd_next_per", per, 20);

        // Invalid loads leave 5/0 active
        step(2);
        do_load(2, 3);
        check("inv1_err", int'(ratio_err), 1);
        do_load(1, 0);
        check("inv2_err", int'(ratio_err), 1);
        wait_done(cnt);
        measure(per, hi, md);
        check("inv_per", per, 20);
        check("inv_hi", hi, 12);
        check("inv_err_hold", int'(ratio_err), 1);

        // Valid 4/1 clears the error: 17 cycles, high 5+4
        step(2);
        do_load(4, 1);
        check("v41_err", int'(ratio_err), 0);
        wait_done(cnt);
        measure(per, hi, md);
        check("v41_per", per, 17);
        check("v41_hi", hi, 9);
        check("v41_mod", md, 5);

        // Max ratio 63/3: 255 cycles, high 3*5 + 29*4 = 131
        step(2);
        do_load(63, 3);
        wait_done(cnt);
        measure(per, hi, md);
        check("max_per", per, 255);
        check("max_hi", hi, 131);
        check("max_mod", md, 15);
        measure(per, hi, md);
        check("max_per2", per, 255);

        // Reset mid-period with a valid ratio pending and an error flagged
        step(135);
        do_load(3, 0);
        do_load(1, 0);
        check("pre_rst_err", int'(ratio_err), 1);
        check("pre_rst_clk", int'(clk_out), 0);
        rstb = 1'b0;
        #1;
        check("mrst_clk_out", int'(clk_out), 1);
        check("mrst_err", int'(ratio_err), 0);
        check("mrst_done", int'(cycle_done), 0);
        check("mrst_mod", int'(mod_ctrl), 0);
        p_val = 6'd3; s_val = 2'd0; load = 1'b1;
        step(3);
        load = 1'b0;
        rstb = 1'b1;
        wait_done(cnt);
        check("mrst_first_per", cnt, 19);
        measure(per, hi, md);
        check("mrst_per", per, 20);
        check("mrst_hi", hi, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
